// File: rtl/hilo_mul_ctrl_if.sv
// Execute-side request channel, multiplier handshake and HI/LO result view
// for hilo_mul_ctrl. The controller uses the slave modport.
interface hilo_mul_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        mul_valid;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_done;
  logic [63:0] mul_c;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        wb_valid;

  modport master (
    output req_valid, req_op, req_a, req_b, flush, mul_done, mul_c,
    input  req_ready, mul_valid, mul_a, mul_b, hi, lo, busy, wb_valid
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, flush, mul_done, mul_c,
    output req_ready, mul_valid, mul_a, mul_b, hi, lo, busy, wb_valid
  );
endinterface

// File: rtl/hilo_mul_ctrl.sv
// HI/LO owner in front of an unsigned 32x32 multiplier: takes operand magnitudes,
// sign-corrects the product and writes, adds or subtracts it into {hi,lo}.
//
// state | meaning
// IDLE  | ready for a request; moves and zero-operand products finish here
// ISSUE | multiplier running on held mul_a/mul_b, waiting for mul_done
module hilo_mul_ctrl #(
  parameter bit ZERO_SKIP = 1'b1
) (
  input logic           clk,
  input logic           resetn,
  hilo_mul_ctrl_if.slave bus
);

  typedef enum logic [0:0] {IDLE, ISSUE} state_t;
  typedef enum logic [1:0] {K_SET, K_ADD, K_SUB} kind_t;

  state_t      state, next_state;
  kind_t       kind, req_kind, wr_kind;
  logic [31:0] hi, lo, mul_a, mul_b;
  logic        neg, wb_valid;

  logic        req_ready, accept, op_is_move, op_signed, zero_hit;
  logic [31:0] mag_a, mag_b;
  logic        wr_result, wr_hi, wr_lo, start_issue;
  logic [63:0] wr_prod, acc, new_acc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state  = state;
    req_ready   = (state == IDLE) && !bus.flush;
    accept      = bus.req_valid && req_ready;
    op_is_move  = (bus.req_op[2:1] == 2'b11);
    op_signed   = !bus.req_op[0] && !op_is_move;
    // 0x80000000 negates to itself, which is exactly its unsigned magnitude
    mag_a       = (op_signed && bus.req_a[31]) ? -bus.req_a : bus.req_a;
    mag_b       = (op_signed && bus.req_b[31]) ? -bus.req_b : bus.req_b;
    zero_hit    = ZERO_SKIP && ((mag_a == 32'd0) || (mag_b == 32'd0));
    case (bus.req_op[2:1])
      2'b01:   req_kind = K_ADD;
      2'b10:   req_kind = K_SUB;
      default: req_kind = K_SET;
    endcase
    wr_result   = 1'b0;
    wr_hi       = accept && (bus.req_op == 3'd6);
    wr_lo       = accept && (bus.req_op == 3'd7);
    wr_prod     = 64'd0;
    wr_kind     = kind;
    start_issue = 1'b0;

    case (state)
      IDLE: begin
        if (accept && !op_is_move) begin
          if (zero_hit) begin
            wr_result = 1'b1;
            wr_kind   = req_kind;
          end else begin
            start_issue = 1'b1;
            next_state  = ISSUE;
          end
        end
      end
      ISSUE: begin
        // flush wins over a same-cycle mul_done
        if (bus.flush) begin
          next_state = IDLE;
        end else if (bus.mul_done) begin
          next_state = IDLE;
          wr_result  = 1'b1;
          wr_prod    = neg ? -bus.mul_c : bus.mul_c;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    acc = {hi, lo};
    case (wr_kind)
      K_ADD:   new_acc = acc + wr_prod;
      K_SUB:   new_acc = acc - wr_prod;
      default: new_acc = wr_prod;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi       <= 32'd0;
      lo       <= 32'd0;
      mul_a    <= 32'd0;
      mul_b    <= 32'd0;
      neg      <= 1'b0;
      kind     <= K_SET;
      wb_valid <= 1'b0;
    end else begin
      wb_valid <= wr_result || wr_hi || wr_lo;
      if (wr_result) begin
        hi <= new_acc[63:32];
        lo <= new_acc[31:0];
      end
      if (wr_hi) hi <= bus.req_a;
      if (wr_lo) lo <= bus.req_a;
      if (start_issue) begin
        mul_a <= mag_a;
        mul_b <= mag_b;
        neg   <= op_signed && (bus.req_a[31] ^ bus.req_b[31]);
        kind  <= req_kind;
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.mul_valid = (state == ISSUE);
  assign bus.mul_a     = mul_a;
  assign bus.mul_b     = mul_b;
  assign bus.hi        = hi;
  assign bus.lo        = lo;
  assign bus.busy      = (state != IDLE);
  assign bus.wb_valid  = wb_valid;

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Directed bench for hilo_mul_ctrl with a behavioural 2-cycle multiplier that
// raises mul_done on the second mul_valid cycle and also whenever it is idle.
module tb_hilo_mul_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   passed = 0;
  int   total = 0;
  int   mcnt = 0;
  logic mv_seen = 1'b0;

  hilo_mul_ctrl_if bus();

  hilo_mul_ctrl #(.ZERO_SKIP(1'b1)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mcnt <= bus.mul_valid ? mcnt + 1 : 0;
    if (bus.mul_valid) mv_seen <= 1'b1;
  end

  always_comb begin
    bus.mul_done = !bus.mul_valid || (mcnt == 1);
    bus.mul_c    = {32'd0, bus.mul_a} * {32'd0, bus.mul_b};
  end

  // Presents one request for a single cycle; returns at the negedge after the accept edge.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) $display("FAIL reset_hilo hi=%h lo=%h want 0", bus.hi, bus.lo); else passed++;
    total++; if (bus.busy !== 1'b0 || bus.mul_valid !== 1'b0 || bus.wb_valid !== 1'b0) $display("FAIL reset_ctl busy=%b mv=%b wb=%b want 0", bus.busy, bus.mul_valid, bus.wb_valid); else passed++;
    total++; if (bus.mul_a !== 32'd0 || bus.mul_b !== 32'd0) $display("FAIL reset_mul mul_a=%h mul_b=%h want 0", bus.mul_a, bus.mul_b); else passed++;
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) $display("FAIL reset_ready req_ready=%b want 1", bus.req_ready); else passed++;
  endtask

  task automatic test_mult_min;
    send(3'd0, 32'h8000_0000, 32'h8000_0000);
    total++; if (bus.mul_valid !== 1'b1 || bus.busy !== 1'b1) $display("FAIL min_issue mv=%b busy=%b want 1", bus.mul_valid, bus.busy); else passed++;
    total++; if (bus.mul_a !== 32'h8000_0000 || bus.mul_b !== 32'h8000_0000) $display("FAIL min_mag mul_a=%h mul_b=%h want 80000000", bus.mul_a, bus.mul_b); else passed++;
    @(negedge clk);
    total++; if (bus.mul_valid !== 1'b1 || bus.hi !== 32'd0 || bus.wb_valid !== 1'b0) $display("FAIL min_issue2 mv=%b hi=%h wb=%b want 1/0/0", bus.mul_valid, bus.hi, bus.wb_valid); else passed++;
    @(negedge clk);
    total++; if (bus.hi !== 32'h4000_0000 || bus.lo !== 32'd0) $display("FAIL min_result hi=%h lo=%h want 40000000/0", bus.hi, bus.lo); else passed++;
    total++; if (bus.wb_valid !== 1'b1 || bus.busy !== 1'b0 || bus.mul_valid !== 1'b0) $display("FAIL min_wb wb=%b busy=%b mv=%b want 1/0/0", bus.wb_valid, bus.busy, bus.mul_valid); else passed++;
    @(negedge clk);
    total++; if (bus.wb_valid !== 1'b0) $display("FAIL min_wb_pulse wb=%b want 0", bus.wb_valid); else passed++;
  endtask

  task automatic test_mult_sign;
    send(3'd0, 32'hFFFF_FFFF, 32'd1);
    total++; if (bus.mul_a !== 32'd1 || bus.mul_b !== 32'd1) $display("FAIL sign_mag mul_a=%h mul_b=%h want 1/1", bus.mul_a, bus.mul_b); else passed++;
    @(negedge clk); @(negedge clk);
    total++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFF) $display("FAIL mult_neg hi=%h lo=%h want ffffffff/ffffffff", bus.hi, bus.lo); else passed++;
    send(3'd1, 32'hFFFF_FFFF, 32'd1);
    total++; if (bus.mul_a !== 32'hFFFF_FFFF) $display("FAIL multu_mag mul_a=%h want ffffffff", bus.mul_a); else passed++;
    @(negedge clk); @(negedge clk);
    total++; if (bus.hi !== 32'd0 || bus.lo !== 32'hFFFF_FFFF) $display("FAIL multu hi=%h lo=%h want 0/ffffffff", bus.hi, bus.lo); else passed++;
  endtask

  task automatic test_accumulate;
    send(3'd6, 32'hFFFF_FFFF, 32'd0);
    total++; if (bus.hi !== 32'hFFFF_FFFF || bus.wb_valid !== 1'b1 || bus.busy !== 1'b0) $display("FAIL mthi hi=%h wb=%b busy=%b want ffffffff/1/0", bus.hi, bus.wb_valid, bus.busy); else passed++;
    send(3'd7, 32'hFFFF_FFFF, 32'd0);
    total++; if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'hFFFF_FFFF) $display("FAIL mtlo hi=%h lo=%h want ffffffff/ffffffff", bus.hi, bus.lo); else passed++;
    send(3'd3, 32'd1, 32'd1);
    @(negedge clk); @(negedge clk);
    total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.wb_valid !== 1'b1) $display("FAIL maddu_wrap hi=%h lo=%h wb=%b want 0/0/1", bus.hi, bus.lo, bus.wb_valid); else passed++;
    send(3'd4, 32'd1, 32'd1);
    @(negedge clk); @(negedge clk);
    total++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFF) $display("FAIL msub hi=%h lo=%h want ffffffff/ffffffff", bus.hi, bus.lo); else passed++;
  endtask

  task automatic test_flush;
    send(3'd0, 32'd3, 32'd5);
    total++; if (bus.busy !== 1'b1) $display("FAIL flush_busy busy=%b want 1", bus.busy); else passed++;
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.mul_valid !== 1'b0 || bus.wb_valid !== 1'b0) $display("FAIL flush_state busy=%b mv=%b wb=%b want 0/0/0", bus.busy, bus.mul_valid, bus.wb_valid); else passed++;
    total++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFF) $display("FAIL flush_hilo hi=%h lo=%h want ffffffff/ffffffff", bus.hi, bus.lo); else passed++;
    total++; if (bus.req_ready !== 1'b1) $display("FAIL flush_ready req_ready=%b want 1", bus.req_ready); else passed++;
    @(negedge clk);
    total++; if (bus.wb_valid !== 1'b0 || bus.lo !== 32'hFFFF_FFFF) $display("FAIL flush_late wb=%b lo=%h want 0/ffffffff", bus.wb_valid, bus.lo); else passed++;
  endtask

  task automatic test_flush_idle;
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd6;
    bus.req_a     = 32'h1234_5678;
    #1;
    total++; if (bus.req_ready !== 1'b0) $display("FAIL flush_idle_ready req_ready=%b want 0", bus.req_ready); else passed++;
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    total++; if (bus.hi !== 32'hFFFF_FFFF || bus.wb_valid !== 1'b0) $display("FAIL flush_idle_drop hi=%h wb=%b want ffffffff/0", bus.hi, bus.wb_valid); else passed++;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    mv_seen = 1'b0;
    send(3'd1, 32'd0, 32'd7);
    total++; if (bus.wb_valid !== 1'b1 || bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0) $display("FAIL zskip wb=%b hi=%h lo=%h busy=%b want 1/0/0/0", bus.wb_valid, bus.hi, bus.lo, bus.busy); else passed++;
    total++; if (mv_seen !== 1'b0) $display("FAIL zskip_mv mul_valid_seen=%b want 0", mv_seen); else passed++;
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd0;
    bus.req_a     = 32'd2;
    bus.req_b     = 32'd3;
    #1;
    total++; if (bus.req_ready !== 1'b1) $display("FAIL b2b_ready req_ready=%b want 1", bus.req_ready); else passed++;
    @(negedge clk);
    bus.req_valid = 1'b0;
    total++; if (bus.busy !== 1'b1 || bus.wb_valid !== 1'b0) $display("FAIL b2b_accept busy=%b wb=%b want 1/0", bus.busy, bus.wb_valid); else passed++;
    @(negedge clk); @(negedge clk);
    total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd6) $display("FAIL b2b_result hi=%h lo=%h want 0/6", bus.hi, bus.lo); else passed++;
    send(3'd2, 32'hFFFF_FFFE, 32'd3);
    @(negedge clk); @(negedge clk);
    total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) $display("FAIL madd_neg hi=%h lo=%h want 0/0", bus.hi, bus.lo); else passed++;
  endtask

  task automatic test_reset_mid;
    send(3'd6, 32'h1234_5678, 32'd0);
    send(3'd1, 32'd2, 32'd3);
    total++; if (bus.busy !== 1'b1 || bus.hi !== 32'h1234_5678) $display("FAIL rmid_pre busy=%b hi=%h want 1/12345678", bus.busy, bus.hi); else passed++;
    resetn = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.mul_valid !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) $display("FAIL rmid busy=%b mv=%b hi=%h lo=%h want 0/0/0/0", bus.busy, bus.mul_valid, bus.hi, bus.lo); else passed++;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    bus.flush     = 1'b0;
    test_reset;
    test_mult_min;
    test_mult_sign;
    test_accumulate;
    test_flush;
    test_flush_idle;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
